// File: rtl/robot_link_pkg.sv
// Shared definitions for the robot serial link (sensor RX and motor TX paths).
package robot_link_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        ID,
        VAL,
        CSUM
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_state_t;

    localparam logic [7:0] STREAM_HEADER   = 8'd19;
    localparam logic [7:0] PKT_BUMPS_DROPS = 8'd7;
    localparam logic [7:0] PKT_WALL        = 8'd8;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, samples mid-bit, flags framing errors.
module uart_rx
    import robot_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       rx_ferr
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_t      state, state_next;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (rx_prev && !rx_sync) state_next = RX_START;
            RX_START: if (cnt == HALF_END) state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt == BIT_END && bit_idx == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (cnt == BIT_END) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    // The counter restarts on every state change, so data bits are timed from the start-bit midpoint.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            bit_idx    <= 3'd0;
            data       <= 8'd0;
            byte_valid <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            if (state == RX_IDLE || state_next != state || cnt == BIT_END)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (state == RX_START)
                bit_idx <= 3'd0;
            else if (state == RX_DATA && cnt == BIT_END) begin
                data    <= {rx_sync, data[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            byte_valid <= (state == RX_STOP) && (cnt == BIT_END) && rx_sync;
            rx_ferr    <= (state == RX_STOP) && (cnt == BIT_END) && !rx_sync;
        end
    end

endmodule

// File: rtl/robot_sensor_rx.sv
// Sensor stream receiver: parses checksummed robot frames into bump/drop/wall flags.
module robot_sensor_rx
    import robot_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int MAX_LEN      = 8,
    parameter int BYTE_TIMEOUT = 50000,
    parameter int LINK_TIMEOUT = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    output logic       bump_right,
    output logic       bump_left,
    output logic       wheel_drop,
    output logic       wall,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       link_ok
);

    localparam int IDLE_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int LINK_W = $clog2(LINK_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(BYTE_TIMEOUT);
    localparam logic [LINK_W-1:0] LINK_MAX = LINK_W'(LINK_TIMEOUT);

    logic [7:0]        data;
    logic              byte_valid, rx_ferr;
    parser_state_t     state, state_next;
    logic [7:0]        sum, remaining, csum_total;
    logic              cur_wall, seen_bumps, seen_wall, shadow_wall;
    logic [3:0]        shadow_bumps;
    logic [IDLE_W-1:0] idle_cnt;
    logic [LINK_W-1:0] link_cnt;
    logic              timeout, commit_c, err_c;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (uart_in),
        .data       (data),
        .byte_valid (byte_valid),
        .rx_ferr    (rx_ferr)
    );

    assign csum_total = sum + data;
    assign timeout    = (state != HUNT) && !byte_valid && (idle_cnt == IDLE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        commit_c   = 1'b0;
        err_c      = 1'b0;
        if (state != HUNT && (rx_ferr || timeout)) begin
            err_c      = 1'b1;
            state_next = HUNT;
        end else if (byte_valid) begin
            case (state)
                HUNT: if (data == STREAM_HEADER) state_next = LEN;
                LEN: begin
                    if (data == 8'd0 || data[0] || data > 8'(MAX_LEN)) begin
                        err_c      = 1'b1;
                        state_next = HUNT;
                    end else
                        state_next = ID;
                end
                ID: begin
                    if (data == PKT_BUMPS_DROPS || data == PKT_WALL)
                        state_next = VAL;
                    else begin
                        err_c      = 1'b1;
                        state_next = HUNT;
                    end
                end
                VAL:  state_next = (remaining == 8'd1) ? CSUM : ID;
                CSUM: begin
                    commit_c   = (csum_total == 8'd0);
                    err_c      = (csum_total != 8'd0);
                    state_next = HUNT;
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // Accepted bytes are recognised by the transition they cause, so abort paths never touch the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum          <= 8'd0;
            remaining    <= 8'd0;
            cur_wall     <= 1'b0;
            seen_bumps   <= 1'b0;
            seen_wall    <= 1'b0;
            shadow_bumps <= 4'd0;
            shadow_wall  <= 1'b0;
            bump_right   <= 1'b0;
            bump_left    <= 1'b0;
            wheel_drop   <= 1'b0;
            wall         <= 1'b0;
        end else begin
            case (state)
                HUNT: if (state_next == LEN) begin
                    sum        <= data;
                    seen_bumps <= 1'b0;
                    seen_wall  <= 1'b0;
                end
                LEN: if (state_next == ID) begin
                    remaining <= data;
                    sum       <= sum + data;
                end
                ID: if (state_next == VAL) begin
                    cur_wall  <= (data == PKT_WALL);
                    sum       <= sum + data;
                    remaining <= remaining - 8'd1;
                end
                VAL: if (state_next == ID || state_next == CSUM) begin
                    if (cur_wall) begin
                        shadow_wall <= data[0];
                        seen_wall   <= 1'b1;
                    end else begin
                        shadow_bumps <= data[3:0];
                        seen_bumps   <= 1'b1;
                    end
                    sum       <= sum + data;
                    remaining <= remaining - 8'd1;
                end
                default: ;
            endcase

            if (commit_c) begin
                if (seen_bumps) begin
                    bump_right <= shadow_bumps[0];
                    bump_left  <= shadow_bumps[1];
                    wheel_drop <= shadow_bumps[2] | shadow_bumps[3];
                end
                if (seen_wall)
                    wall <= shadow_wall;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= 8'd0;
            idle_cnt    <= '0;
            link_cnt    <= '0;
            link_ok     <= 1'b0;
        end else begin
            frame_valid <= commit_c;
            frame_err   <= err_c;
            if (err_c && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            if (state == HUNT || byte_valid)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + 1'b1;

            if (commit_c) begin
                link_ok  <= 1'b1;
                link_cnt <= '0;
            end else if (link_cnt == LINK_MAX)
                link_ok <= 1'b0;
            else
                link_cnt <= link_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_robot_sensor_rx.sv
// Table-driven bench for robot_sensor_rx with short UART bit times and timeouts.
module tb_robot_sensor_rx;

    localparam int CPB = 8;
    localparam int BT  = 300;
    localparam int LT  = 8000;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_in;
    logic       bump_right, bump_left, wheel_drop, wall;
    logic       frame_valid, frame_err, link_ok;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;
    int fv_total = 0;
    int fe_total = 0;
    int both_hits = 0;

    typedef struct {
        logic [0:11][7:0] b;
        int               n;
        int               bad;
        int               fv;
        int               fe;
        logic [3:0]       flags;
        logic [7:0]       ec;
        logic             lk;
    } vec_t;

    vec_t vecs[10];

    robot_sensor_rx #(
        .CLKS_PER_BIT (CPB),
        .MAX_LEN      (8),
        .BYTE_TIMEOUT (BT),
        .LINK_TIMEOUT (LT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_in     (uart_in),
        .bump_right  (bump_right),
        .bump_left   (bump_left),
        .wheel_drop  (wheel_drop),
        .wall        (wall),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_count   (err_count),
        .link_ok     (link_ok)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_total++;
        if (frame_err) fe_total++;
        if (frame_valid && frame_err) both_hits++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task checkFlags(input string tag, input logic [3:0] flags, input logic [7:0] ec, input logic lk);
        checkOutput({tag, ".bump_right"}, 32'(bump_right), 32'(flags[0]));
        checkOutput({tag, ".bump_left"},  32'(bump_left),  32'(flags[1]));
        checkOutput({tag, ".wheel_drop"}, 32'(wheel_drop), 32'(flags[2]));
        checkOutput({tag, ".wall"},       32'(wall),       32'(flags[3]));
        checkOutput({tag, ".err_count"},  32'(err_count),  32'(ec));
        checkOutput({tag, ".link_ok"},    32'(link_ok),    32'(lk));
    endtask

    task sendByte(input logic [7:0] b, input logic bad_stop);
        @(negedge clk);
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_in = ~bad_stop;
        repeat (CPB) @(negedge clk);
        uart_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task applyStimulus(input vec_t v);
        for (int i = 0; i < v.n; i++)
            sendByte(v.b[i], i == v.bad);
        repeat (20) @(negedge clk);
    endtask

    task setVec(input int idx, input logic [0:11][7:0] b, input int n, input int bad,
                input int fv, input int fe, input logic [3:0] flags, input logic [7:0] ec,
                input logic lk);
        vecs[idx].b     = b;
        vecs[idx].n     = n;
        vecs[idx].bad   = bad;
        vecs[idx].fv    = fv;
        vecs[idx].fe    = fe;
        vecs[idx].flags = flags;
        vecs[idx].ec    = ec;
        vecs[idx].lk    = lk;
    endtask

    initial begin
        int fv0, fe0;
        // flags = {wall, wheel_drop, bump_left, bump_right}
        setVec(0, {8'd19, 8'd2, 8'd7, 8'h03, 8'hE1, 56'h0}, 5, -1, 1, 0, 4'b0011, 8'd0, 1'b1);
        setVec(1, {8'd19, 8'd4, 8'd7, 8'h0C, 8'd8, 8'h01, 8'hCD, 40'h0}, 7, -1, 1, 0, 4'b1100, 8'd0, 1'b1);
        setVec(2, {8'd19, 8'd2, 8'd7, 8'h01, 8'h00, 56'h0}, 5, -1, 0, 1, 4'b1100, 8'd1, 1'b1);
        setVec(3, {8'd19, 8'd2, 8'd7, 8'h13, 8'hD1, 56'h0}, 5, -1, 1, 0, 4'b1011, 8'd1, 1'b1);
        setVec(4, {8'd19, 8'd2, 8'd7, 8'h01, 8'hE3, 56'h0}, 5, 1, 0, 1, 4'b1011, 8'd2, 1'b1);
        setVec(5, {8'd19, 8'd2, 8'd9, 8'h01, 8'hD3, 56'h0}, 5, -1, 0, 1, 4'b1011, 8'd3, 1'b1);
        setVec(6, {8'd19, 8'd3, 8'd7, 8'h00, 8'hDF, 56'h0}, 5, -1, 0, 1, 4'b1011, 8'd4, 1'b1);
        setVec(7, {8'd19, 8'd10, 80'h0}, 2, -1, 0, 1, 4'b1011, 8'd5, 1'b1);
        setVec(8, {8'd19, 8'd8, 8'd7, 8'h00, 8'd8, 8'h00, 8'd7, 8'h04, 8'd8, 8'h00, 8'hC3, 8'h0},
               11, -1, 1, 0, 4'b0100, 8'd5, 1'b1);
        setVec(9, {8'd19, 8'd0, 80'h0}, 2, -1, 0, 1, 4'b0100, 8'd6, 1'b1);

        rst = 1'b1;
        uart_in = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset.frame_valid", 32'(frame_valid), 32'd0);
        checkOutput("reset.frame_err", 32'(frame_err), 32'd0);
        checkFlags("reset", 4'b0000, 8'd0, 1'b0);
        rst = 1'b0;
        repeat (4 * CPB) @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            fv0 = fv_total;
            fe0 = fe_total;
            applyStimulus(vecs[k]);
            checkOutput($sformatf("vec%0d.frame_valid_pulses", k), 32'(fv_total - fv0), 32'(vecs[k].fv));
            checkOutput($sformatf("vec%0d.frame_err_pulses", k), 32'(fe_total - fe0), 32'(vecs[k].fe));
            checkFlags($sformatf("vec%0d", k), vecs[k].flags, vecs[k].ec, vecs[k].lk);
        end

        // Stall after the LEN byte: no abort before BYTE_TIMEOUT, exactly one abort after it.
        fe0 = fe_total;
        sendByte(8'd19, 1'b0);
        sendByte(8'd2, 1'b0);
        repeat (150) @(negedge clk);
        checkOutput("timeout.early_err", 32'(fe_total - fe0), 32'd0);
        repeat (300) @(negedge clk);
        checkOutput("timeout.err_pulses", 32'(fe_total - fe0), 32'd1);
        checkOutput("timeout.err_count", 32'(err_count), 32'd7);
        fv0 = fv_total;
        applyStimulus(vecs[0]);
        checkOutput("timeout.resync_valid", 32'(fv_total - fv0), 32'd1);
        checkFlags("timeout.resync", 4'b0011, 8'd7, 1'b1);

        // Link drops only after LINK_TIMEOUT without a good frame; flags hold.
        repeat (LT - 200) @(negedge clk);
        checkOutput("link.before_timeout", 32'(link_ok), 32'd1);
        repeat (300) @(negedge clk);
        checkFlags("link.dropped", 4'b0011, 8'd7, 1'b0);

        // Reset in the middle of the third byte of a frame.
        sendByte(8'd19, 1'b0);
        sendByte(8'd4, 1'b0);
        @(negedge clk);
        uart_in = 1'b0;
        repeat (CPB + 3) @(negedge clk);
        uart_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset.frame_valid", 32'(frame_valid), 32'd0);
        checkOutput("midreset.frame_err", 32'(frame_err), 32'd0);
        checkFlags("midreset", 4'b0000, 8'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        fv0 = fv_total;
        fe0 = fe_total;
        applyStimulus(vecs[1]);
        checkOutput("postreset.frame_valid_pulses", 32'(fv_total - fv0), 32'd1);
        checkOutput("postreset.frame_err_pulses", 32'(fe_total - fe0), 32'd0);
        checkFlags("postreset", 4'b1100, 8'd0, 1'b1);

        checkOutput("valid_err_overlap", 32'(both_hits), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/robot_sensor_rx.md
Name: robot_sensor_rx

Overview:
Receive side of the robot serial link. The motor command path transmits drive opcodes to the robot. This block receives the robot's sensor stream on the UART RX pin, deserialises 8N1 bytes and parses stream frames. It publishes checksum-verified bump, wheel-drop and wall flags to the waiter FSM, which uses them to force the STOP state.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud)
MAX_LEN, 8, largest accepted frame length byte; longer frames are rejected
BYTE_TIMEOUT, 50000, idle clk cycles mid-frame before the parser abandons the frame (1 ms)
LINK_TIMEOUT, 5000000, clk cycles without a good frame before link_ok drops (100 ms)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
uart_in  in  1  serial data from robot; idles high
bump_right  out  1  packet 7 bit0
bump_left  out  1  packet 7 bit1
wheel_drop  out  1  packet 7 bit2 OR bit3
wall  out  1  packet 8 bit0
frame_valid  out  1  one-cycle pulse when a good frame commits
frame_err  out  1  one-cycle pulse on any rejected or aborted frame
err_count  out  8  saturating count of frame_err pulses
link_ok  out  1  high while a good frame has arrived within LINK_TIMEOUT

Behaviour:
- Reset (async, active-high): all outputs 0; synchroniser flops 1; parser in HUNT; all counters 0.
- UART receive (sub-module):
  - uart_in passes through a 2-flop synchroniser.
  - A falling edge while idle starts a bit counter. The start bit is re-sampled at CLKS_PER_BIT/2; if it is high, return to idle (glitch).
  - Eight data bits are sampled LSB first, every CLKS_PER_BIT from the start-bit mid-point.
  - Stop bit sampled high: byte_valid pulses 1 cycle with the data. Latency from stop-bit mid-point to pulse is 1 clk.
  - Stop bit sampled low: rx_ferr pulses 1 cycle and the byte is dropped.
  - Idle is re-armed immediately after the stop sample.
- Frame format: 19 (header), N (length), then N/2 (id, value) pairs, then checksum. The 8-bit sum of all bytes including the checksum must be 0.
- Parser FSM states: HUNT, LEN, ID, VAL, CSUM.
  - HUNT: byte 19 -> sum=19, go to LEN. Any other byte is ignored silently.
  - LEN: N=0, N odd, or N>MAX_LEN -> frame_err, go to HUNT. Otherwise remaining=N, sum+=N, go to ID.
  - ID: id must be 7 or 8, otherwise frame_err and go to HUNT. Otherwise latch the id, sum+=byte, remaining-=1, go to VAL.
  - VAL: write the byte into the shadow register for the latched id, sum+=byte, remaining-=1. Go to CSUM if remaining==0, else ID. A repeated id in one frame: the last value wins.
  - CSUM: if (sum+byte)==0, copy shadows into outputs for the ids present in this frame only, pulse frame_valid, go to HUNT. Otherwise frame_err and go to HUNT; outputs unchanged.
- Outputs change only on a frame_valid cycle.
- A data byte equal to 19 is treated as data; header search happens only in HUNT.
- rx_ferr in any state other than HUNT: frame_err, go to HUNT. rx_ferr in HUNT: ignored.
- Mid-frame timeout: an idle counter resets on each byte_valid. Reaching BYTE_TIMEOUT outside HUNT gives frame_err and a return to HUNT.
- err_count increments on each frame_err and saturates at 255. frame_valid and frame_err are never high in the same cycle.
- link_ok:
  - Set on frame_valid, and its counter clears.
  - Cleared when the counter reaches LINK_TIMEOUT.
  - Sensor flags hold their last value when the link drops; the consumer gates them with link_ok.

Decomposition:
- Package robot_link_pkg: parser state enum, constant STREAM_HEADER=19, PKT_BUMPS_DROPS=7, PKT_WALL=8, and the default CLKS_PER_BIT. This package is shared with the motor TX modules.
- Sub-module uart_rx (params CLKS_PER_BIT; ports clk, rst, rx, data[7:0], byte_valid, rx_ferr). The parser and timers live in robot_sensor_rx.

Test Plan:
- Good frame with bumps: bytes 19,2,7,0x03,0xE1 -> frame_valid pulse once; bump_right=1, bump_left=1, wheel_drop=0; link_ok=1; err_count=0.
- Two-packet frame: 19,4,7,0x0C,8,0x01,0xCD -> wheel_drop=1, wall=1, bumps=0.
- Bad checksum: 19,2,7,0x01,0x00 -> frame_err pulse; prior outputs held; err_count=1. A following good frame still commits.
- Header value inside data: 19,2,7,0x13,0xD1 -> accepted; bump_right=1, bump_left=1, wheel_drop=0 from 0x13. No resync on the data 19.
- Faults: low stop bit in the second byte -> frame_err and HUNT. Unknown id 9 -> frame_err. Line idle for 1 ms after the LEN byte -> frame_err. Idle for 100 ms -> link_ok=0.
- Reset asserted mid-byte and mid-frame -> all outputs 0 immediately. After release, a complete good frame parses correctly.
